// File: rtl/wb_write_arb_if.sv
// Register-file write-back bus: pipeline write, long-latency valid/ready result, and the registered RF write port.
interface wb_write_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
    input  lu_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
    output lu_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_write_arb.sv
// Write-back arbiter: pipeline writes win, long-latency results drain through a small FIFO with squash-on-overwrite.
// Optional WB_STATS_EN adds saturating deferral/squash counters; otherwise stat outputs are tied to 0.
module wb_write_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_write_arb_if.slave           bus,
  output logic [2**ADDR_W-1:0]    pend_mask,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [15:0]             stat_defer,
  output logic [15:0]             stat_squash
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  live, live_nxt, kill;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;

  logic sel_pipe, empty, accept, pop, direct, lu_kill, push;

  assign bus.lu_ready = !rst && (count != (PTR_W+1)'(DEPTH));
  assign q_count      = count;

  always_comb begin
    sel_pipe = bus.pipe_we && (bus.pipe_waddr != '0);
    empty    = (count == '0);
    accept   = bus.lu_valid && bus.lu_ready;
    pop      = !sel_pipe && !empty;
    direct   = !sel_pipe && empty && accept;
    // A concurrent pipe write to the same register is newer, so the lu result is dropped
    lu_kill  = accept && sel_pipe && (bus.lu_waddr == bus.pipe_waddr);
    push     = accept && !direct && (bus.lu_waddr != '0) && !lu_kill;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = sel_pipe && live[i] && (mem_addr[i] == bus.pipe_waddr);
    end
    live_nxt = live & ~kill;
    if (pop)  live_nxt[rd_ptr] = 1'b0;
    if (push) live_nxt[wr_ptr] = 1'b1;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pend_mask[mem_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      live   <= live_nxt;
      count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.lu_waddr;
      mem_data[wr_ptr] <= bus.lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (sel_pipe) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= bus.pipe_waddr;
      bus.rf_wdata <= bus.pipe_wdata;
    end else if (pop) begin
      // Dead entries still cost a slot but never reach the register file
      bus.rf_we <= live[rd_ptr];
      if (live[rd_ptr]) begin
        bus.rf_waddr <= mem_addr[rd_ptr];
        bus.rf_wdata <= mem_data[rd_ptr];
      end
    end else if (direct && (bus.lu_waddr != '0)) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= bus.lu_waddr;
      bus.rf_wdata <= bus.lu_wdata;
    end else begin
      bus.rf_we <= 1'b0;
    end
  end

`ifdef WB_STATS_EN
  logic squash_evt;
  assign squash_evt = lu_kill || (|kill);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_defer  <= '0;
      stat_squash <= '0;
    end else begin
      if (push && (stat_defer != 16'hFFFF))        stat_defer  <= stat_defer + 16'd1;
      if (squash_evt && (stat_squash != 16'hFFFF)) stat_squash <= stat_squash + 16'd1;
    end
  end
`else
  assign stat_defer  = '0;
  assign stat_squash = '0;
`endif
endmodule

// File: tb/tb_wb_write_arb.sv
// Bench for wb_write_arb: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_write_arb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_write_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  logic [2**ADDR_W-1:0]   pend_mask;
  logic [$clog2(DEPTH):0] q_count;
  logic [15:0]            stat_defer, stat_squash;

  wb_write_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pend_mask  (pend_mask),
    .q_count    (q_count),
    .stat_defer (stat_defer),
    .stat_squash(stat_squash)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                live;
  } ent_t;

  ent_t              q[$];
  bit                exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  int                exp_defer, exp_squash;
  int                checks, failures;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2**ADDR_W-1:0] model_mask();
    logic [2**ADDR_W-1:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].a] = 1'b1;
    return m;
  endfunction

  // Reference: pipe beats everything, then FIFO head, then a bypassing lu result
  task automatic model_step(input bit pw, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                            input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    bit sel, acc, was_empty, killed;
    ent_t e;
    if (rst) begin
      q.delete();
      exp_we = 0; exp_addr = '0; exp_data = '0;
      exp_defer = 0; exp_squash = 0;
      return;
    end
    sel       = pw && (pa != 0);
    acc       = lv && (q.size() < DEPTH);
    was_empty = (q.size() == 0);
    killed    = 0;
    exp_we    = 0;
    if (sel) begin
      exp_we = 1; exp_addr = pa; exp_data = pd;
      foreach (q[i]) if (q[i].live && q[i].a == pa) begin q[i].live = 0; killed = 1; end
      if (acc && la == pa) killed = 1;
    end else if (!was_empty) begin
      e = q.pop_front();
      if (e.live) begin exp_we = 1; exp_addr = e.a; exp_data = e.d; end
    end else if (acc && la != 0) begin
      exp_we = 1; exp_addr = la; exp_data = ld;
    end
    if (acc && !(!sel && was_empty) && la != 0 && !(sel && la == pa)) begin
      e.a = la; e.d = ld; e.live = 1;
      q.push_back(e);
      if (exp_defer < 16'hFFFF) exp_defer++;
    end
    if (killed && exp_squash < 16'hFFFF) exp_squash++;
  endtask

  task automatic compare_all();
    chk("rf_we", bus.rf_we, exp_we);
    if (exp_we) begin
      chk("rf_waddr", bus.rf_waddr, exp_addr);
      chk("rf_wdata", bus.rf_wdata, exp_data);
    end
    chk("q_count", q_count, q.size());
    chk("pend_mask", pend_mask, model_mask());
    chk("lu_ready", bus.lu_ready, (!rst && q.size() != DEPTH));
`ifdef WB_STATS_EN
    chk("stat_defer", stat_defer, exp_defer);
    chk("stat_squash", stat_squash, exp_squash);
`else
    chk("stat_defer", stat_defer, 0);
    chk("stat_squash", stat_squash, 0);
`endif
  endtask

  task automatic step(input bit pw, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                      input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    bus.pipe_we = pw; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
    bus.lu_valid = lv; bus.lu_waddr = la; bus.lu_wdata = ld;
    model_step(pw, pa, pd, lv, la, ld);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    bit pw, lv, lh, acc_pre;
    logic [ADDR_W-1:0] pa, la;
    logic [DATA_W-1:0] pd, ld;
    checks = 0; failures = 0;

    // Reset held with active requests
    rst = 1'b1;
    step(1, 5, 32'h1, 1, 7, 32'h2);
    step(1, 5, 32'h1, 1, 7, 32'h2);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    rst = 1'b0;
    bus.pipe_we = 0; bus.lu_valid = 0;
    #1;
    chk("rst_rel_ready", bus.lu_ready, 1);

    // Plain pipe write
    step(1, 5, 32'h12345678, 0, '0, '0);
    chk("pipe_we", bus.rf_we, 1);
    chk("pipe_data", bus.rf_wdata, 32'h12345678);

    // Conflict: lu deferred behind pipe
    step(1, 3, 32'hA, 1, 7, 32'hB);
    chk("conf_pend7", pend_mask[7], 1);
    chk("conf_qcnt", q_count, 1);
    idle();
    chk("conf_lu_addr", bus.rf_waddr, 7);
    chk("conf_lu_data", bus.rf_wdata, 32'hB);
    idle();

    // Fill, block, then drain in order
    step(1, 1, 32'h1, 1, 8, 32'h11);
    step(1, 2, 32'h2, 1, 9, 32'h22);
    chk("full_ready", bus.lu_ready, 0);
    step(1, 3, 32'h3, 1, 10, 32'h33);
    step(0, '0, '0, 1, 10, 32'h33);
    chk("drain_r8", bus.rf_wdata, 32'h11);
    step(0, '0, '0, 1, 10, 32'h33);
    chk("drain_r9", bus.rf_wdata, 32'h22);
    idle();
    chk("drain_r10", bus.rf_wdata, 32'h33);
    idle();

    // Squash of a queued write by a newer pipe write
    step(1, 1, 32'h5, 1, 9, 32'hDEAD);
    step(1, 9, 32'hBEEF, 0, '0, '0);
    chk("sq_data", bus.rf_wdata, 32'hBEEF);
    chk("sq_pend9", pend_mask[9], 0);
    idle();
    chk("sq_dead_we", bus.rf_we, 0);
    idle();

    // r0 handling
    step(1, 0, 32'h77, 0, '0, '0);
    chk("r0_pipe_we", bus.rf_we, 0);
    step(0, '0, '0, 1, 0, 32'h99);
    chk("r0_lu_we", bus.rf_we, 0);
    idle();

    // Random traffic; an unaccepted lu result is held stable
    lh = 0; lv = 0; la = '0; ld = '0;
    for (int n = 0; n < 3000; n++) begin
      pw = ($urandom_range(0, 1) == 1);
      pa = ADDR_W'($urandom_range(0, 4));
      pd = $urandom;
      if (!lh) begin
        lv = ($urandom_range(0, 2) != 0);
        la = ADDR_W'($urandom_range(0, 4));
        ld = $urandom;
      end
      acc_pre = lv && (q.size() < DEPTH);
      step(pw, pa, pd, lv, la, ld);
      lh = lv && !acc_pre;
    end
    idle();
    idle();

    // Reset mid-operation with a full queue
    step(1, 1, 32'h1, 1, 12, 32'hC);
    step(1, 2, 32'h2, 1, 13, 32'hD);
    rst = 1'b1;
    step(0, '0, '0, 1, 14, 32'hE);
    rst = 1'b0;
    idle();
    idle();
    chk("post_rst_we", bus.rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
